fpu_op_scheduler: RTL and testbench
===================================

Name: fpu_op_scheduler

Overview:
- Single-issue front end that accepts tagged FP requests and dispatches them to the four FPU units: add/sub and mult (fully pipelined, fixed latency), and divide and sqrt (iterative, one op in flight each).
- A writeback reservation shift register guarantees at most one unit completes per cycle.
- Results return in completion order on one tagged response port.
- Sits between the core's FP issue stage and the fpu_add/fpu_mult/fpu_divide/fpu_sqrt wrappers.

Parameters:
- ADD_LAT, 3, cycles from add issue to add unit ready pulse
- MUL_LAT, 3, cycles from mult issue to mult ready pulse
- DIV_LAT, 28, cycles from divide issue to divide ready pulse
- SQRT_LAT, 28, cycles from sqrt issue to sqrt ready pulse
- TAG_W, 4, request/response tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5-7 illegal
- req_mode  in  3  fpu_round_mode_t, passed through
- req_a, req_b  in  32  operands (b ignored for sqrt)
- req_tag  in  TAG_W  returned with result
- unit_a, unit_b  out  32  shared operand bus to all units
- unit_mode  out  3  shared rounding mode
- unit_sub  out  1  negate b for add unit
- add_valid, mul_valid, div_valid, sqrt_valid  out  1  one-cycle issue strobes
- add_y, mul_y, div_y, sqrt_y  in  32  unit results
- add_ready, mul_ready, div_ready, sqrt_ready  in  1  unit completion pulses
- rsp_valid  out  1  response valid (no backpressure)
- rsp_y  out  32  result
- rsp_tag  out  TAG_W  tag of completed op
- rsp_illegal  out  1  op was illegal
- err  out  1  sticky latency-mismatch flag (see optional feature)

Behaviour:
- Reset (rst=0, async): all reservation slots cleared, div/sqrt busy cleared. rsp_valid=0, rsp_y=0, rsp_tag=0, rsp_illegal=0, err=0. All unit strobes 0.
- Reset mid-operation discards in-flight ops; no response is ever produced for them. Units share the same reset.
- LAT(op): ADD_LAT for 0/1, MUL_LAT for 2, DIV_LAT for 3, SQRT_LAT for 4, 1 for illegal.
- MAXL = max of all latencies.
- Reservation register: MAXL+1 entries of {busy, unit id, tag}. It shifts toward slot 0 every cycle.
- req_ready = !slot[LAT(req_op)].busy && !(op==3 && div_busy) && !(op==4 && sqrt_busy).
- req_ready depends on req_op but never on req_valid.
- Issue at cycle t (valid&ready):
  - unit_a/b/mode/sub driven combinationally from req_*.
  - Matching unit strobe high for cycle t only.
  - Entry written into slot LAT(op), already accounting for the same-cycle shift.
- Illegal ops (5-7): no unit strobe; they only occupy the writeback slot.
- div_busy set at issue and cleared when its slot reaches 0. sqrt_busy behaves the same way.
- Completion: unit ready pulses at cycle t+LAT. At t+LAT+1 (registered):
  - rsp_valid=1.
  - rsp_y = the unit's y sampled at t+LAT, or 0x7FC00000 for illegal ops.
  - rsp_tag = the issued tag.
  - rsp_illegal = 1 for illegal ops, else 0.
- rsp_valid is high for exactly one cycle per accepted request. Responses never collide.
- A new request may issue in the same cycle the slot it targets is being vacated by the shift.
- Order: out-of-order completion is allowed (e.g. an add issued after a div returns first). Tags identify results.
- Unit ready pulses with no matching slot-0 entry are ignored.

Optional Feature:
- Macro: FPU_SCHED_CHECK_EN.
- Defined: each cycle, any unit ready pulse must coincide with a slot-0 entry for that unit, and vice versa.
  - Any mismatch sets err=1, sticky until reset.
  - The response still issues from the reservation, using whatever the unit y bus holds.
- Undefined: no checking logic; err tied 0.

Test Plan:
- Back-to-back adds: tags 1,2,3 issued on cycles 0,1,2, units pulse at 3,4,5 -> rsp_valid on cycles 4,5,6 with tags 1,2,3; req_ready stays 1.
- Writeback collision: div (tag 5) issued at cycle 0, add (tag 6) offered at cycle 25 -> req_ready=0 at cycle 25 (slot 3 reserved). Add issues at cycle 26. Responses: tag 5 at cycle 29, tag 6 at cycle 30.
- Iterative busy: second div offered 1 cycle after the first -> req_ready=0 until cycle 28. A sqrt offered meanwhile issues immediately.
- Illegal op 6, tag 9 -> no unit strobe; rsp_valid 2 cycles after issue with rsp_y=0x7FC00000, rsp_illegal=1, rsp_tag=9.
- Reset asserted 10 cycles after a div issue -> all outputs 0 during reset. After release: no response for that tag, and a new div is accepted immediately.
- With FPU_SCHED_CHECK_EN: mult ready forced one cycle late -> err=1 and stays 1 until reset. Without the macro -> err=0.

Source files
------------

// File: rtl/fpu_op_scheduler.sv
// Single-issue FP op scheduler: dispatches to add/mul/div/sqrt units, reserves writeback slots.
// Optional macro FPU_SCHED_CHECK_EN enables the sticky unit-latency mismatch flag on err.
module fpu_op_scheduler #(
  parameter int ADD_LAT  = 3,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 28,
  parameter int SQRT_LAT = 28,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [2:0]       req_mode,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  output logic [2:0]       unit_mode,
  output logic             unit_sub,
  output logic             add_valid,
  output logic             mul_valid,
  output logic             div_valid,
  output logic             sqrt_valid,
  input  logic [31:0]      add_y,
  input  logic [31:0]      mul_y,
  input  logic [31:0]      div_y,
  input  logic [31:0]      sqrt_y,
  input  logic             add_ready,
  input  logic             mul_ready,
  input  logic             div_ready,
  input  logic             sqrt_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             err
);

  localparam int MAX_AM = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_DS = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int MAXL_R = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
  localparam int MAXL   = (MAXL_R > 1) ? MAXL_R : 1;
  localparam int SW     = $clog2(MAXL + 1);

  localparam logic [2:0]  U_ADD  = 3'd0;
  localparam logic [2:0]  U_MUL  = 3'd1;
  localparam logic [2:0]  U_DIV  = 3'd2;
  localparam logic [2:0]  U_SQRT = 3'd3;
  localparam logic [2:0]  U_ILL  = 3'd4;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  function automatic logic [SW-1:0] lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: lat_of = SW'(ADD_LAT);
      3'd2:       lat_of = SW'(MUL_LAT);
      3'd3:       lat_of = SW'(DIV_LAT);
      3'd4:       lat_of = SW'(SQRT_LAT);
      default:    lat_of = SW'(1);
    endcase
  endfunction

  function automatic logic [2:0] unit_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: unit_of = U_ADD;
      3'd2:       unit_of = U_MUL;
      3'd3:       unit_of = U_DIV;
      3'd4:       unit_of = U_SQRT;
      default:    unit_of = U_ILL;
    endcase
  endfunction

  logic [MAXL:0]      slot_busy_q, slot_busy_d;
  logic [2:0]         slot_unit_q [MAXL+1];
  logic [2:0]         slot_unit_d [MAXL+1];
  logic [TAG_W-1:0]   slot_tag_q  [MAXL+1];
  logic [TAG_W-1:0]   slot_tag_d  [MAXL+1];
  logic               div_busy_q, div_busy_d;
  logic               sqrt_busy_q, sqrt_busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_y_q, rsp_y_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_illegal_q, rsp_illegal_d;

  logic [SW-1:0]      req_lat_s;
  logic [2:0]         req_unit_s;
  logic               slot_hit_s;
  logic               req_ready_s;
  logic               issue_s;

  // Acceptance: the writeback slot this op would land in must be free.
  always_comb begin
    req_lat_s  = lat_of(req_op);
    req_unit_s = unit_of(req_op);
    slot_hit_s = 1'b0;
    for (int k = 0; k <= MAXL; k++) begin
      slot_hit_s = slot_hit_s | (slot_busy_q[k] & (req_lat_s == SW'(k)));
    end
    req_ready_s = !slot_hit_s
                  && !((req_unit_s == U_DIV) && div_busy_q)
                  && !((req_unit_s == U_SQRT) && sqrt_busy_q);
    issue_s = req_valid && req_ready_s && rst;
  end

  assign req_ready  = req_ready_s;
  assign unit_a     = req_a;
  assign unit_b     = req_b;
  assign unit_mode  = req_mode;
  assign unit_sub   = (req_op == 3'd1);
  assign add_valid  = issue_s && (req_unit_s == U_ADD);
  assign mul_valid  = issue_s && (req_unit_s == U_MUL);
  assign div_valid  = issue_s && (req_unit_s == U_DIV);
  assign sqrt_valid = issue_s && (req_unit_s == U_SQRT);

  // The new entry lands one slot below LAT because the whole register shifts this same edge.
  always_comb begin
    for (int k = 0; k < MAXL; k++) begin
      if (issue_s && (req_lat_s == SW'(k + 1))) begin
        slot_busy_d[k] = 1'b1;
        slot_unit_d[k] = req_unit_s;
        slot_tag_d[k]  = req_tag;
      end else begin
        slot_busy_d[k] = slot_busy_q[k+1];
        slot_unit_d[k] = slot_unit_q[k+1];
        slot_tag_d[k]  = slot_tag_q[k+1];
      end
    end
    slot_busy_d[MAXL] = 1'b0;
    slot_unit_d[MAXL] = 3'd0;
    slot_tag_d[MAXL]  = {TAG_W{1'b0}};

    if (issue_s && (req_unit_s == U_DIV)) begin
      div_busy_d = 1'b1;
    end else if (slot_busy_q[1] && (slot_unit_q[1] == U_DIV)) begin
      div_busy_d = 1'b0;
    end else begin
      div_busy_d = div_busy_q;
    end

    if (issue_s && (req_unit_s == U_SQRT)) begin
      sqrt_busy_d = 1'b1;
    end else if (slot_busy_q[1] && (slot_unit_q[1] == U_SQRT)) begin
      sqrt_busy_d = 1'b0;
    end else begin
      sqrt_busy_d = sqrt_busy_q;
    end
  end

  // Slot 0 names the unit finishing this cycle; its y bus is captured into the response.
  always_comb begin
    if (slot_busy_q[0]) begin
      rsp_valid_d   = 1'b1;
      rsp_tag_d     = slot_tag_q[0];
      rsp_illegal_d = (slot_unit_q[0] == U_ILL);
      case (slot_unit_q[0])
        U_ADD:   rsp_y_d = add_y;
        U_MUL:   rsp_y_d = mul_y;
        U_DIV:   rsp_y_d = div_y;
        U_SQRT:  rsp_y_d = sqrt_y;
        default: rsp_y_d = QNAN;
      endcase
    end else begin
      rsp_valid_d   = 1'b0;
      rsp_tag_d     = {TAG_W{1'b0}};
      rsp_illegal_d = 1'b0;
      rsp_y_d       = 32'd0;
    end
  end

  // Reservation register and iterative-unit busy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_busy_q <= '0;
      for (int k = 0; k <= MAXL; k++) begin
        slot_unit_q[k] <= 3'd0;
        slot_tag_q[k]  <= {TAG_W{1'b0}};
      end
      div_busy_q  <= 1'b0;
      sqrt_busy_q <= 1'b0;
    end else begin
      slot_busy_q <= slot_busy_d;
      for (int k = 0; k <= MAXL; k++) begin
        slot_unit_q[k] <= slot_unit_d[k];
        slot_tag_q[k]  <= slot_tag_d[k];
      end
      div_busy_q  <= div_busy_d;
      sqrt_busy_q <= sqrt_busy_d;
    end
  end

  // Registered response port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_y_q       <= 32'd0;
      rsp_tag_q     <= {TAG_W{1'b0}};
      rsp_illegal_q <= 1'b0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_y_q       <= rsp_y_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_illegal = rsp_illegal_q;

`ifdef FPU_SCHED_CHECK_EN
  logic [3:0] slot0_exp_s;
  logic       mismatch_s;
  logic       err_q, err_d;

  // Every unit pulse must line up with a slot-0 reservation for that unit, and vice versa.
  always_comb begin
    slot0_exp_s[0] = slot_busy_q[0] && (slot_unit_q[0] == U_ADD);
    slot0_exp_s[1] = slot_busy_q[0] && (slot_unit_q[0] == U_MUL);
    slot0_exp_s[2] = slot_busy_q[0] && (slot_unit_q[0] == U_DIV);
    slot0_exp_s[3] = slot_busy_q[0] && (slot_unit_q[0] == U_SQRT);
    mismatch_s = |(slot0_exp_s ^ {sqrt_ready, div_ready, mul_ready, add_ready});
    err_d      = err_q | mismatch_s;
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_ready_s;
  assign unused_ready_s = ^{add_ready, mul_ready, div_ready, sqrt_ready};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Self-checking bench for fpu_op_scheduler: directed scenarios plus random traffic
// checked against a completion-cycle reservation model; emulates the four FPU units.
module tb_fpu_op_scheduler;

  localparam int          TAG_W = 4;
  localparam int          NCYC  = 2048;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [2:0]       req_mode;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      unit_a, unit_b;
  logic [2:0]       unit_mode;
  logic             unit_sub;
  logic             add_valid, mul_valid, div_valid, sqrt_valid;
  logic [31:0]      add_y, mul_y, div_y, sqrt_y;
  logic             add_ready, mul_ready, div_ready, sqrt_ready;
  logic             rsp_valid;
  logic [31:0]      rsp_y;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;
  logic             err;

  fpu_op_scheduler #(.ADD_LAT(3), .MUL_LAT(3), .DIV_LAT(28), .SQRT_LAT(28), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .unit_a(unit_a), .unit_b(unit_b), .unit_mode(unit_mode), .unit_sub(unit_sub),
    .add_valid(add_valid), .mul_valid(mul_valid), .div_valid(div_valid), .sqrt_valid(sqrt_valid),
    .add_y(add_y), .mul_y(mul_y), .div_y(div_y), .sqrt_y(sqrt_y),
    .add_ready(add_ready), .mul_ready(mul_ready), .div_ready(div_ready), .sqrt_ready(sqrt_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit last_acc;
  int acc_cyc;
  bit mul_late;
  int err_from;
  int div_free, sqrt_free;

  // Model state indexed by absolute cycle number.
  bit               wb_res [NCYC];
  bit               ev     [NCYC];
  bit               eychk  [NCYC];
  bit               eill   [NCYC];
  logic [31:0]      ey     [NCYC];
  logic [TAG_W-1:0] etag   [NCYC];
  bit [3:0]         pulse_at [NCYC];
  logic [31:0]      yv_at  [NCYC][4];

  function automatic int unit_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 0;
      3'd2:       return 1;
      3'd3:       return 2;
      3'd4:       return 3;
      default:    return -1;
    endcase
  endfunction

  function automatic int lat_u(input int u);
    case (u)
      0, 1:    return 3;
      2, 3:    return 28;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] unit_fn(input int u, input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] mode, input logic sub);
    logic [31:0] m;
    m = {29'd0, mode};
    case (u)
      0:       return (a + (sub ? (~b + 32'd1) : b)) ^ m;
      1:       return (a * b) ^ m;
      2:       return a ^ {b[15:0], b[31:16]} ^ m;
      default: return ~a ^ m;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", name, obs, expv, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCYC; i++) begin
      wb_res[i] = 1'b0; ev[i] = 1'b0; eychk[i] = 1'b0; eill[i] = 1'b0;
      ey[i] = 32'd0; etag[i] = '0; pulse_at[i] = 4'd0;
    end
    div_free = 0; sqrt_free = 0; err_from = -1; mul_late = 1'b0;
  endtask

  task automatic tick();
    int u, l, p;
    bit ready_m, err_m;
    logic [3:0] strb_m, strb;
    @(negedge clk);
    strb = {sqrt_valid, div_valid, mul_valid, add_valid};
    if (!rst) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_y", rsp_y, 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_strobes", 32'(strb), 32'd0);
      last_acc = 1'b0;
    end else begin
      u = unit_of(req_op);
      l = (u < 0) ? 1 : lat_u(u);
      ready_m = !wb_res[cyc + l] && !(u == 2 && div_free > cyc) && !(u == 3 && sqrt_free > cyc);
      chk("req_ready", 32'(req_ready), 32'(ready_m));
      last_acc = req_valid && ready_m;
      strb_m = 4'd0;
      if (last_acc && u >= 0) strb_m[u] = 1'b1;
      chk("unit_strobes", 32'(strb), 32'(strb_m));
      if (last_acc && u >= 0) begin
        chk("unit_a", unit_a, req_a);
        chk("unit_b", unit_b, req_b);
        chk("unit_mode", 32'(unit_mode), 32'(req_mode));
        if (u == 0) chk("unit_sub", 32'(unit_sub), 32'(req_op == 3'd1));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev[cyc]));
      if (ev[cyc]) begin
        chk("rsp_tag", 32'(rsp_tag), 32'(etag[cyc]));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(eill[cyc]));
        if (eychk[cyc]) chk("rsp_y", rsp_y, ey[cyc]);
      end
`ifdef FPU_SCHED_CHECK_EN
      err_m = (err_from >= 0) && (cyc >= err_from);
`else
      err_m = 1'b0;
`endif
      chk("err", 32'(err), 32'(err_m));
      if (last_acc) begin
        acc_cyc = cyc;
        wb_res[cyc + l] = 1'b1;
        ev[cyc + l + 1] = 1'b1;
        eychk[cyc + l + 1] = 1'b1;
        etag[cyc + l + 1] = req_tag;
        eill[cyc + l + 1] = (u < 0);
        ey[cyc + l + 1] = (u < 0) ? QNAN : unit_fn(u, req_a, req_b, req_mode, req_op == 3'd1);
        if (u == 2) div_free = cyc + l;
        if (u == 3) sqrt_free = cyc + l;
      end
      // Unit emulation: each strobe produces a ready pulse LAT cycles later.
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) begin
          p = cyc + lat_u(k);
          if (k == 1 && mul_late) begin
            eychk[p + 1] = 1'b0;
            err_from = p + 1;
            p = p + 1;
            mul_late = 1'b0;
          end
          pulse_at[p][k] = 1'b1;
          yv_at[p][k] = unit_fn(k, unit_a, unit_b, unit_mode, unit_sub);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    add_ready  = pulse_at[cyc][0];
    mul_ready  = pulse_at[cyc][1];
    div_ready  = pulse_at[cyc][2];
    sqrt_ready = pulse_at[cyc][3];
    add_y  = pulse_at[cyc][0] ? yv_at[cyc][0] : $urandom();
    mul_y  = pulse_at[cyc][1] ? yv_at[cyc][1] : $urandom();
    div_y  = pulse_at[cyc][2] ? yv_at[cyc][2] : $urandom();
    sqrt_y = pulse_at[cyc][3] ? yv_at[cyc][3] : $urandom();
  endtask

  task automatic offer(input logic [2:0] op, input logic [TAG_W-1:0] tag, input int bound);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    req_a     = $urandom();
    req_b     = $urandom();
    req_mode  = 3'($urandom_range(0, 7));
    for (int i = 0; i < bound; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("offer_accepted", 32'(last_acc), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    int t0;
    clear_model();
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_mode = 3'd0;
    req_a = 32'd0; req_b = 32'd0; req_tag = '0;
    add_ready = 1'b0; mul_ready = 1'b0; div_ready = 1'b0; sqrt_ready = 1'b0;
    add_y = 32'd0; mul_y = 32'd0; div_y = 32'd0; sqrt_y = 32'd0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Back-to-back adds, tags 1..3.
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = 3'd0; req_tag = 4'(i + 1);
      req_a = $urandom(); req_b = $urandom(); req_mode = 3'd0;
      tick();
      chk("b2b_issue_cycle", 32'(acc_cyc - t0), 32'(i));
    end
    req_valid = 1'b0;
    repeat (8) tick();

    // Writeback collision between a div and a later add.
    t0 = cyc;
    offer(3'd3, 4'd5, 1);
    repeat (24) tick();
    offer(3'd0, 4'd6, 5);
    chk("collision_add_issue", 32'(acc_cyc - t0), 32'd26);
    repeat (8) tick();

    // Iterative busy: second div waits, sqrt slips in.
    t0 = cyc;
    offer(3'd3, 4'd7, 1);
    req_valid = 1'b1; req_op = 3'd3; req_tag = 4'd8;
    tick();
    chk("div_busy_reject", 32'(last_acc), 32'd0);
    offer(3'd4, 4'd10, 1);
    chk("sqrt_issue_cycle", 32'(acc_cyc - t0), 32'd2);
    offer(3'd3, 4'd8, 40);
    chk("div2_issue_cycle", 32'(acc_cyc - t0), 32'd28);
    repeat (32) tick();

    // Illegal op.
    offer(3'd6, 4'd9, 1);
    repeat (4) tick();

    // Random traffic.
    repeat (400) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = 3'($urandom_range(0, 7));
      req_tag   = 4'($urandom_range(0, 15));
      req_a     = $urandom();
      req_b     = $urandom();
      req_mode  = 3'($urandom_range(0, 7));
      tick();
    end
    req_valid = 1'b0;
    repeat (35) tick();

    // Mult ready one cycle late.
    mul_late = 1'b1;
    offer(3'd2, 4'd11, 1);
    repeat (8) tick();
`ifdef FPU_SCHED_CHECK_EN
    chk("err_sticky", 32'(err), 32'd1);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    // Reset ten cycles into a div.
    offer(3'd3, 4'd12, 1);
    repeat (9) tick();
    rst = 1'b0;
    clear_model();
    add_ready = 1'b0; mul_ready = 1'b0; div_ready = 1'b0; sqrt_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    t0 = cyc;
    offer(3'd3, 4'd13, 1);
    chk("div_after_reset", 32'(acc_cyc - t0), 32'd0);
    repeat (35) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
